vec_exec_stage: RTL

- Execute stage directly downstream of the decode/execute pipeline register.
- Consumes 16-lane x 32-bit operand vectors, the sign-extended immediate, ALU control, write-address and memory control bits.
- Scalar ops (v_s_i=0) complete in 1 cycle on lane 0. Vector ops (v_s_i=1) are processed LANES_PER_CYCLE lanes per cycle. stall_o freezes upstream stages until the op completes.
- Results, flags and forwarded control bits go to the execute/memory register.

---
 rtl/vec_exec_pkg.sv | 38 +++
 rtl/vec_lane_alu.sv | 63 ++++++
 rtl/vec_exec_stage.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/vec_exec_pkg.sv
// ============================================================================
// Module   : vec_exec_pkg
// Purpose  : Shared sizes, lane/vector types, ALU opcodes and FSM states
//            for the vector execute stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vec_exec_pkg;

    localparam int LANES           = 16;
    localparam int WIDTH           = 32;
    localparam int LANES_PER_CYCLE = 4;

    typedef logic [WIDTH-1:0]            lane_t;
    typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_ORR = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_LSL = 4'b0101,
        ALU_LSR = 4'b0110,
        ALU_MUL = 4'b0111,
        ALU_MOV = 4'b1000
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/vec_lane_alu.sv
// ============================================================================
// Module   : vec_lane_alu
// Purpose  : Combinational single-lane ALU producing a result and {N,Z,C,V}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_lane_alu
    import vec_exec_pkg::*;
#(
    parameter int WIDTH = vec_exec_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       nzcv
);

    localparam int MSB  = WIDTH - 1;
    localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] prod;
    logic             carry;
    logic             ovf;

    // The extra top bit of sum/diff is the carry out / borrow out.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign prod = a * b;

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            ALU_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                res   = diff[WIDTH-1:0];
                carry = ~diff[WIDTH];
                ovf   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
            end
            ALU_AND: res = a & b;
            ALU_ORR: res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_LSL: res = a << b[SH_W-1:0];
            ALU_LSR: res = a >> b[SH_W-1:0];
            ALU_MUL: res = prod;
            ALU_MOV: res = b;
            default: res = '0;
        endcase
        nzcv = {res[MSB], (res == '0), carry, ovf};
    end

endmodule

`default_nettype wire

// File: rtl/vec_exec_stage.sv
// ============================================================================
// Module   : vec_exec_stage
// Purpose  : Execute stage; scalar ops in one cycle on lane 0, vector ops
//            LANES_PER_CYCLE lanes per cycle while stalling upstream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_exec_stage
    import vec_exec_pkg::*;
#(
    parameter int LANES           = vec_exec_pkg::LANES,
    parameter int WIDTH           = vec_exec_pkg::WIDTH,
    parameter int LANES_PER_CYCLE = vec_exec_pkg::LANES_PER_CYCLE
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   valid_i,
    input  logic                   v_s_i,
    input  logic [3:0]             alu_ctrl_i,
    input  logic                   alu_src_i,
    input  logic [LANES*WIDTH-1:0] a_i,
    input  logic [LANES*WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0]       imm_i,
    input  logic [3:0]             wa3_i,
    input  logic                   regwrite_i,
    input  logic                   memtoreg_i,
    input  logic                   memwrite_i,
    output logic [LANES*WIDTH-1:0] result_o,
    output logic [3:0]             flags_o,
    output logic [3:0]             wa3_o,
    output logic                   regwrite_o,
    output logic                   memtoreg_o,
    output logic                   memwrite_o,
    output logic                   v_s_o,
    output logic                   done_o,
    output logic                   stall_o
);

    localparam int GROUPS = LANES / LANES_PER_CYCLE;
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_e                               state;
    state_e                               state_next;
    logic [GRP_W-1:0]                     grp;
    logic                                 last_grp;
    logic                                 accept;
    alu_op_e                              op_q;
    alu_op_e                              op_sel;
    logic [LANES-1:0][WIDTH-1:0]          a_vec;
    logic [LANES-1:0][WIDTH-1:0]          b_vec;
    logic [LANES-1:0][WIDTH-1:0]          opa;
    logic [LANES-1:0][WIDTH-1:0]          opb;
    logic [LANES-1:0][WIDTH-1:0]          result;
    logic [LANES_PER_CYCLE-1:0][WIDTH-1:0] alu_a;
    logic [LANES_PER_CYCLE-1:0][WIDTH-1:0] alu_b;
    logic [LANES_PER_CYCLE-1:0][WIDTH-1:0] alu_res;
    logic [LANES_PER_CYCLE-1:0][LANE_W-1:0] lane_idx;
    logic [3:0]                           scalar_nzcv;

    assign a_vec    = a_i;
    assign b_vec    = alu_src_i ? {LANES{imm_i}} : b_i;
    assign accept   = valid_i && (state != RUN);
    assign last_grp = (grp == GRP_W'(GROUPS - 1));
    // While running, the ALUs must see the op captured at accept time.
    assign op_sel   = (state == RUN) ? op_q : alu_op_e'(alu_ctrl_i);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall_o    = 1'b0;
        done_o     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = v_s_i ? RUN : DONE;
            end
            RUN: begin
                stall_o = 1'b1;
                if (last_grp) state_next = DONE;
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = accept ? (v_s_i ? RUN : DONE) : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    for (genvar k = 0; k < LANES_PER_CYCLE; k++) begin : g_lane
        assign lane_idx[k] = LANE_W'(grp) * LANE_W'(LANES_PER_CYCLE) + LANE_W'(k);

        if (k == 0) begin : g_scalar_mux
            // Lane 0 doubles as the scalar datapath outside RUN.
            assign alu_a[k] = (state == RUN) ? opa[lane_idx[k]] : a_vec[0];
            assign alu_b[k] = (state == RUN) ? opb[lane_idx[k]] : b_vec[0];

            vec_lane_alu #(.WIDTH(WIDTH)) u_alu (
                .a    (alu_a[k]),
                .b    (alu_b[k]),
                .op   (op_sel),
                .res  (alu_res[k]),
                .nzcv (scalar_nzcv)
            );
        end else begin : g_vec_only
            logic [3:0] nzcv_unused;

            assign alu_a[k] = opa[lane_idx[k]];
            assign alu_b[k] = opb[lane_idx[k]];

            vec_lane_alu #(.WIDTH(WIDTH)) u_alu (
                .a    (alu_a[k]),
                .b    (alu_b[k]),
                .op   (op_sel),
                .res  (alu_res[k]),
                .nzcv (nzcv_unused)
            );
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grp        <= '0;
            op_q       <= ALU_ADD;
            opa        <= '0;
            opb        <= '0;
            result     <= '0;
            flags_o    <= '0;
            wa3_o      <= '0;
            regwrite_o <= 1'b0;
            memtoreg_o <= 1'b0;
            memwrite_o <= 1'b0;
            v_s_o      <= 1'b0;
        end else if (accept) begin
            op_q       <= alu_op_e'(alu_ctrl_i);
            wa3_o      <= wa3_i;
            regwrite_o <= regwrite_i;
            memtoreg_o <= memtoreg_i;
            memwrite_o <= memwrite_i;
            v_s_o      <= v_s_i;
            if (v_s_i) begin
                opa <= a_vec;
                opb <= b_vec;
                grp <= '0;
            end else begin
                result  <= {{((LANES - 1) * WIDTH){1'b0}}, alu_res[0]};
                flags_o <= scalar_nzcv;
            end
        end else if (state == RUN) begin
            for (int k = 0; k < LANES_PER_CYCLE; k++) begin
                result[lane_idx[k]] <= alu_res[k];
            end
            grp <= last_grp ? '0 : grp + GRP_W'(1);
        end
    end

    assign result_o = result;

endmodule

`default_nettype wire
